ts_bitpack_fifo: RTL and testbench

//  Parametrised bit-packing FIFO for the TS recorder datapath.
//  - Accepts SYM_W-bit symbols and packs them MSB-first, gap-free, into a circular store of DEPTH words of WORD_W bits.
//  - Symbols may straddle word boundaries and buffer wrap.
//  - Returns the symbols in order on a valid/ready read port.
//  - Sits between the symbol source and the word-wide capture/storage logic.

---
 rtl/ts_bitpack_fifo.sv | 102 ++++++++++
 tb/tb_ts_bitpack_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ts_bitpack_fifo.sv
// Bit-packing FIFO: SYM_W-bit symbols packed MSB-first, gap-free, into DEPTH words of WORD_W bits.
// Read data is a combinational gather at the read pointer; symbols may straddle words and wrap.
module ts_bitpack_fifo #(
  parameter int SYM_W  = 10,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int PTR_W  = $clog2(WORD_W*DEPTH)
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              WR_VALID,
  input  logic [SYM_W-1:0]  WR_DATA,
  output logic              WR_READY,
  input  logic              RD_READY,
  output logic              RD_VALID,
  output logic [SYM_W-1:0]  RD_DATA,
  output logic [PTR_W:0]    LEVEL_BITS,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVF_STICKY,
  output logic              UNF_STICKY,
  input  logic [ADDR_W-1:0] DBG_SEL,
  output logic [WORD_W-1:0] DBG_WORD
);

  localparam int             WB      = $clog2(WORD_W);
  localparam logic [PTR_W:0] TOTAL_L = (PTR_W+1)'(WORD_W*DEPTH);
  localparam logic [PTR_W:0] SYM_L   = (PTR_W+1)'(SYM_W);

  logic [DEPTH-1:0][WORD_W-1:0] mem;
  logic [DEPTH-1:0][WORD_W-1:0] wr_mask;
  logic [DEPTH-1:0][WORD_W-1:0] wr_bits;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [PTR_W-1:0]             wr_b, rd_b;
  logic [PTR_W:0]               level;
  logic                         wr_acc, rd_acc;

  // Flags come from the registered level only, so a same-cycle read never frees space early.
  assign WR_READY   = (TOTAL_L - level) >= SYM_L;
  assign RD_VALID   = level >= SYM_L;
  assign FULL       = !WR_READY;
  assign EMPTY      = !RD_VALID;
  assign LEVEL_BITS = level;
  assign DBG_WORD   = mem[DBG_SEL];

  assign wr_acc = WR_VALID & WR_READY;
  assign rd_acc = RD_READY & RD_VALID;

  // Global bit b lives in word b/WORD_W at index WORD_W-1-(b%WORD_W); ~b[WB-1:0] gives that index.
  always_comb begin
    wr_mask = '0;
    wr_bits = '0;
    wr_b    = '0;
    for (int i = 0; i < SYM_W; i++) begin
      wr_b = wr_ptr + PTR_W'(i);
      wr_mask[wr_b[PTR_W-1:WB]][~wr_b[WB-1:0]] = 1'b1;
      wr_bits[wr_b[PTR_W-1:WB]][~wr_b[WB-1:0]] = WR_DATA[SYM_W-1-i];
    end
  end

  always_comb begin
    RD_DATA = '0;
    rd_b    = '0;
    for (int i = 0; i < SYM_W; i++) begin
      rd_b = rd_ptr + PTR_W'(i);
      RD_DATA[SYM_W-1-i] = mem[rd_b[PTR_W-1:WB]][~rd_b[WB-1:0]];
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      OVF_STICKY <= 1'b0;
      UNF_STICKY <= 1'b0;
    end else if (FLUSH) begin
      // Storage contents are deliberately left as-is; only bookkeeping is cleared.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      OVF_STICKY <= 1'b0;
      UNF_STICKY <= 1'b0;
    end else begin
      if (wr_acc) begin
        mem    <= (mem & ~wr_mask) | wr_bits;
        wr_ptr <= wr_ptr + PTR_W'(SYM_W);
      end
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_W'(SYM_W);
      level <= level + (wr_acc ? SYM_L : '0) - (rd_acc ? SYM_L : '0);
      if (WR_VALID && !WR_READY)
        OVF_STICKY <= 1'b1;
      if (RD_READY && !RD_VALID)
        UNF_STICKY <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ts_bitpack_fifo.sv
// Directed bench for ts_bitpack_fifo with default parameters (10-bit symbols, 16 x 32-bit words).
module tb_ts_bitpack_fifo;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        FLUSH = 1'b0;
  logic        WR_VALID = 1'b0;
  logic [9:0]  WR_DATA = '0;
  logic        WR_READY;
  logic        RD_READY = 1'b0;
  logic        RD_VALID;
  logic [9:0]  RD_DATA;
  logic [9:0]  LEVEL_BITS;
  logic        FULL, EMPTY, OVF_STICKY, UNF_STICKY;
  logic [3:0]  DBG_SEL = '0;
  logic [31:0] DBG_WORD;

  int n_vec = 0;
  int n_bad = 0;

  ts_bitpack_fifo dut (
    .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
    .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .RD_READY(RD_READY), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .LEVEL_BITS(LEVEL_BITS), .FULL(FULL), .EMPTY(EMPTY),
    .OVF_STICKY(OVF_STICKY), .UNF_STICKY(UNF_STICKY),
    .DBG_SEL(DBG_SEL), .DBG_WORD(DBG_WORD)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input logic wv, input logic [9:0] wd, input logic rr);
    WR_VALID = wv;
    WR_DATA  = wd;
    RD_READY = rr;
    @(posedge CLOCK);
    #1;
    WR_VALID = 1'b0;
    RD_READY = 1'b0;
  endtask

  task automatic do_flush();
    FLUSH = 1'b1;
    cyc(1'b0, 10'h0, 1'b0);
    FLUSH = 1'b0;
  endtask

  function automatic logic [9:0] pat_a(input int i);
    return 10'((i * 37 + 5) & 32'h3ff);
  endfunction

  function automatic logic [9:0] pat_b(input int i);
    return 10'((i * 101 + 7) & 32'h3ff);
  endfunction

  logic [9:0] s1 [4] = '{10'h3ff, 10'h001, 10'h2aa, 10'h155};
  logic [9:0] s2 [4] = '{10'h3ff, 10'h000, 10'h3ff, 10'h003};
  logic [9:0] q [$];

  initial begin
    repeat (2) @(posedge CLOCK);
    #1;
    // Reset state
    chk("rst_level", LEVEL_BITS, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_rdvld", RD_VALID, 0);
    chk("rst_wrrdy", WR_READY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_rddat", RD_DATA, 0);
    chk("rst_ovf", OVF_STICKY, 0);
    chk("rst_unf", UNF_STICKY, 0);
    RESET = 1'b0;
    cyc(1'b0, 10'h0, 1'b0);

    // Basic in-order write/read
    foreach (s1[i]) cyc(1'b1, s1[i], 1'b0);
    chk("t1_level40", LEVEL_BITS, 40);
    chk("t1_rdvld", RD_VALID, 1);
    foreach (s1[i]) begin
      chk($sformatf("t1_rd%0d", i), RD_DATA, s1[i]);
      cyc(1'b0, 10'h0, 1'b1);
    end
    chk("t1_level0", LEVEL_BITS, 0);
    chk("t1_empty", EMPTY, 1);

    // Packing layout and word-straddling symbol
    do_flush();
    foreach (s2[i]) cyc(1'b1, s2[i], 1'b0);
    DBG_SEL = 4'd0;
    #1 chk("t2_word0", DBG_WORD, 32'hffc00ffc);
    DBG_SEL = 4'd1;
    #1 chk("t2_word1", DBG_WORD, 32'h03000000);
    foreach (s2[i]) begin
      chk($sformatf("t2_rd%0d", i), RD_DATA, s2[i]);
      cyc(1'b0, 10'h0, 1'b1);
    end

    // Fill to 510 bits, overflow attempt, drain
    do_flush();
    for (int i = 0; i < 51; i++) cyc(1'b1, pat_a(i), 1'b0);
    chk("t3_level510", LEVEL_BITS, 510);
    chk("t3_full", FULL, 1);
    chk("t3_wrrdy", WR_READY, 0);
    chk("t3_ovf_pre", OVF_STICKY, 0);
    cyc(1'b1, 10'h123, 1'b0);
    chk("t3_ovf", OVF_STICKY, 1);
    chk("t3_level_hold", LEVEL_BITS, 510);
    for (int i = 0; i < 51; i++) begin
      chk($sformatf("t3_rd%0d", i), RD_DATA, pat_a(i));
      cyc(1'b0, 10'h0, 1'b1);
    end
    chk("t3_level0", LEVEL_BITS, 0);
    chk("t3_ovf_stays", OVF_STICKY, 1);

    // Simultaneous write+read at level 500, then underflow
    do_flush();
    chk("t4_ovf_flushed", OVF_STICKY, 0);
    for (int i = 0; i < 50; i++) cyc(1'b1, pat_b(i), 1'b0);
    chk("t4_level500", LEVEL_BITS, 500);
    chk("t4_wrrdy", WR_READY, 1);
    chk("t4_rd_both", RD_DATA, pat_b(0));
    cyc(1'b1, pat_b(50), 1'b1);
    chk("t4_level_same", LEVEL_BITS, 500);
    for (int i = 1; i <= 50; i++) begin
      chk($sformatf("t4_rd%0d", i), RD_DATA, pat_b(i));
      cyc(1'b0, 10'h0, 1'b1);
    end
    chk("t4_empty", EMPTY, 1);
    chk("t4_unf_pre", UNF_STICKY, 0);
    cyc(1'b0, 10'h0, 1'b1);
    chk("t4_unf", UNF_STICKY, 1);
    chk("t4_level0", LEVEL_BITS, 0);

    // Random stream with stalls, several pointer wraps
    do_flush();
    begin
      int wr_n = 0;
      int rd_n = 0;
      int cycles = 0;
      logic wv, rr;
      logic [9:0] wd;
      q.delete();
      while (rd_n < 300 && cycles < 5000) begin
        wv = (wr_n < 300) && WR_READY && ($urandom % 4 != 0);
        wd = 10'($urandom);
        rr = RD_VALID && (q.size() > 0) && ($urandom % 3 != 0);
        if (rr) begin
          chk("t5_data", RD_DATA, q.pop_front());
          rd_n++;
        end
        if (wv) begin
          q.push_back(wd);
          wr_n++;
        end
        cyc(wv, wd, rr);
        cycles++;
      end
      chk("t5_count", rd_n, 300);
      chk("t5_level0", LEVEL_BITS, 0);
      chk("t5_ovf", OVF_STICKY, 0);
      chk("t5_unf", UNF_STICKY, 0);
    end

    // FLUSH at level 120 overriding write/read, then async RESET mid-stream
    do_flush();
    cyc(1'b0, 10'h0, 1'b1);
    chk("t6_unf_set", UNF_STICKY, 1);
    for (int i = 0; i < 12; i++) cyc(1'b1, pat_a(i + 3), 1'b0);
    chk("t6_level120", LEVEL_BITS, 120);
    FLUSH = 1'b1;
    cyc(1'b1, 10'h155, 1'b1);
    FLUSH = 1'b0;
    chk("t6_fl_level", LEVEL_BITS, 0);
    chk("t6_fl_rdvld", RD_VALID, 0);
    chk("t6_fl_unf", UNF_STICKY, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, pat_b(i + 9), 1'b0);
    cyc(1'b1, 10'h0, 1'b1);
    cyc(1'b1, 10'h3ff, 1'b0);
    chk("t6_unf_set2", UNF_STICKY, 0);
    cyc(1'b0, 10'h0, 1'b1);
    cyc(1'b0, 10'h0, 1'b1);
    cyc(1'b0, 10'h0, 1'b1);
    cyc(1'b0, 10'h0, 1'b1);
    cyc(1'b0, 10'h0, 1'b1);
    chk("t6_unf_set3", UNF_STICKY, 1);
    cyc(1'b1, 10'h2aa, 1'b0);
    RESET = 1'b1;
    #1;
    chk("t6_rst_level", LEVEL_BITS, 0);
    chk("t6_rst_rdvld", RD_VALID, 0);
    chk("t6_rst_unf", UNF_STICKY, 0);
    chk("t6_rst_rddat", RD_DATA, 0);
    #2 RESET = 1'b0;
    @(posedge CLOCK);
    #1;
    cyc(1'b1, 10'h2c3, 1'b0);
    cyc(1'b1, 10'h0f0, 1'b0);
    chk("t6_level20", LEVEL_BITS, 20);
    chk("t6_rd0", RD_DATA, 10'h2c3);
    cyc(1'b0, 10'h0, 1'b1);
    chk("t6_rd1", RD_DATA, 10'h0f0);
    cyc(1'b0, 10'h0, 1'b1);
    chk("t6_empty", EMPTY, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
